// File: rtl/mcc_accum.sv
// Burst accumulator: sums LEN-word bursts of unsigned 16-bit words into an
// ACC_W-bit total with a sticky overflow flag, delivered over a valid/ready result port.
module mcc_accum #(
   parameter int ACC_W = 24,
   parameter int LEN_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [LEN_W-1:0] len,
   input  logic             in_valid,
   input  logic [15:0]      in_data,
   output logic             in_ready,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_sum,
   output logic             out_ovf,
   output logic             busy,
   output logic [1:0]       fsm_state
);

   // Handshakes: a word moves when in_valid && in_ready on a rising edge; the
   // result moves when out_valid && out_ready. Neither ready depends on the valid.
   localparam int HI_W = ACC_W - 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           next_state;
   logic [LEN_W-1:0] cnt;
   logic [ACC_W-1:0] acc;
   logic             ovf;
   logic             beat;
   logic [15:0]      lo_sum;
   logic             lo_carry;
   logic [HI_W-1:0]  hi_sum;
   logic             hi_carry;

   assign beat = (state == ACC) && in_valid;

   // Low half: explicit ripple chain, carry-in 0.
   always_comb begin
      logic c;
      c      = 1'b0;
      lo_sum = '0;
      for (int i = 0; i < 16; i++) begin
         lo_sum[i] = acc[i] ^ in_data[i] ^ c;
         c         = (acc[i] & in_data[i]) | (c & (acc[i] ^ in_data[i]));
      end
      lo_carry = c;
   end

   // Upper bits only ever increment by the low-half carry.
   assign {hi_carry, hi_sum} = {1'b0, acc[ACC_W-1:16]} + (HI_W+1)'(lo_carry);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE: if (start) next_state = (len == '0) ? DONE : ACC;
         ACC:  if (beat && cnt == LEN_W'(1)) next_state = DONE;
         DONE: if (out_ready) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b1;
      case (state)
         IDLE: busy      = 1'b0;
         ACC:  in_ready  = 1'b1;
         DONE: out_valid = 1'b1;
         default: busy   = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
         acc <= '0;
         ovf <= 1'b0;
      end else if (state == IDLE && start) begin
         cnt <= len;
         acc <= '0;
         ovf <= 1'b0;
      end else if (beat) begin
         cnt <= cnt - LEN_W'(1);
         acc <= {hi_sum, lo_sum};
         if (hi_carry) ovf <= 1'b1;
      end
   end

   assign out_sum   = acc;
   assign out_ovf   = ovf;
   assign fsm_state = state;

endmodule
